// File: rtl/rega_pkg.sv
// -----------------------------------------------------------------------------
// rega_pkg
//   Shared definitions for the irrigation control slice.
//   - state_t    : FSM state codes (ST_IDLE..ST_FALHA), also driven on `estado`
//   - REGA_*     : command / latched mode codes carried on `rega`
//   - DEF_*      : default phase lengths in clock cycles
//   - phase_load : timer preload for a phase length (length 0 behaves as 1)
// -----------------------------------------------------------------------------
package rega_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABRE  = 3'd1,
    ST_REGA  = 3'd2,
    ST_FECHA = 3'd3,
    ST_FALHA = 3'd4
  } state_t;

  localparam logic [1:0] REGA_NONE = 2'b00;
  localparam logic [1:0] REGA_GOT  = 2'b01;
  localparam logic [1:0] REGA_ASP  = 2'b10;
  localparam logic [1:0] REGA_INV  = 2'b11;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_T_ABRE  = 4;
  localparam int DEF_DUR_ASP = 20;
  localparam int DEF_DUR_GOT = 40;
  localparam int DEF_T_FECHA = 4;

  // The timer counts down to 0 inclusive, so a phase of N cycles needs N-1.
  // A zero length collapses to a single-cycle phase.
  function automatic int phase_load(input int len);
    return (len <= 1) ? 0 : len - 1;
  endfunction

endpackage

// File: rtl/temporizador_rega.sv
// -----------------------------------------------------------------------------
// temporizador_rega
//   Loadable down-counter used to time each irrigation phase.
//   Ports:
//     clk      in  clock, rising edge
//     reset    in  asynchronous active-high reset, clears the count
//     load     in  load load_val on the next edge (overrides counting)
//     load_val in  value to load (phase length - 1)
//     zero     out count has reached 0 (counter holds at 0)
// -----------------------------------------------------------------------------
module temporizador_rega #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/controle_rega.sv
// -----------------------------------------------------------------------------
// controle_rega
//   Executes a validated irrigation command: opens the valve for the latched
//   mode, runs the pump, stops the pump and drains, then reports completion.
//   Faults (erro / nivel_baixo) outside IDLE force every actuator off.
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   asynchronous active-high reset
//     rega[1:0]    in   command: 10 aspersao, 01 gotejamento, 00 none, 11 invalid
//     erro         in   upstream validation error
//     nivel_baixo  in   reservoir low
//     valvula_asp  out  aspersao valve
//     valvula_got  out  gotejamento valve
//     bomba        out  pump
//     fim_rega     out  one-cycle pulse on normal completion
//     falha        out  high while in FALHA
//     estado[2:0]  out  current state code
//     ciclos_ok    out  saturating count of completions (REGA_STATS_EN only)
//   Configuration macro: REGA_STATS_EN adds the ciclos_ok port and counter.
// -----------------------------------------------------------------------------
module controle_rega
  import rega_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int T_ABRE  = DEF_T_ABRE,
  parameter int DUR_ASP = DEF_DUR_ASP,
  parameter int DUR_GOT = DEF_DUR_GOT,
  parameter int T_FECHA = DEF_T_FECHA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rega,
  input  logic       erro,
  input  logic       nivel_baixo,
  output logic       valvula_asp,
  output logic       valvula_got,
  output logic       bomba,
  output logic       fim_rega,
  output logic       falha,
  output logic [2:0] estado
`ifdef REGA_STATS_EN
  ,
  output logic [7:0] ciclos_ok
`endif
);

  localparam logic [CNT_W-1:0] LD_ABRE  = CNT_W'(phase_load(T_ABRE));
  localparam logic [CNT_W-1:0] LD_ASP   = CNT_W'(phase_load(DUR_ASP));
  localparam logic [CNT_W-1:0] LD_GOT   = CNT_W'(phase_load(DUR_GOT));
  localparam logic [CNT_W-1:0] LD_FECHA = CNT_W'(phase_load(T_FECHA));

  state_t     state_reg, state_next;
  logic [1:0] mode_reg, mode_next;
  logic       armado_reg, armado_next;
  logic       abortado_reg, abortado_next;

  logic       asp_reg, asp_next;
  logic       got_reg, got_next;
  logic       bomba_reg, bomba_next;
  logic       fim_reg, fim_next;
  logic       falha_reg, falha_next;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;
  logic             fault;

  assign fault = erro | nivel_baixo;

  temporizador_rega #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= REGA_NONE;
      armado_reg   <= 1'b1;
      abortado_reg <= 1'b0;
      asp_reg      <= 1'b0;
      got_reg      <= 1'b0;
      bomba_reg    <= 1'b0;
      fim_reg      <= 1'b0;
      falha_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      armado_reg   <= armado_next;
      abortado_reg <= abortado_next;
      asp_reg      <= asp_next;
      got_reg      <= got_next;
      bomba_reg    <= bomba_next;
      fim_reg      <= fim_next;
      falha_reg    <= falha_next;
    end
  end

  // Next-state logic. Fault outranks abort, abort outranks timer expiry.
  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    armado_next   = armado_reg;
    abortado_next = abortado_reg;
    fim_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Re-arm only after the command has been withdrawn, so a held
        // command runs once.
        if (rega == REGA_NONE) begin
          armado_next = 1'b1;
        end
        if ((rega == REGA_ASP || rega == REGA_GOT) && !fault && armado_reg) begin
          state_next    = ST_ABRE;
          mode_next     = rega;
          armado_next   = 1'b0;
          abortado_next = 1'b0;
        end
      end
      ST_ABRE: begin
        if (fault) begin
          state_next = ST_FALHA;
        end else if (rega != mode_reg) begin
          state_next    = ST_FECHA;
          abortado_next = 1'b1;
        end else if (tmr_zero) begin
          state_next = ST_REGA;
        end
      end
      ST_REGA: begin
        if (fault) begin
          state_next = ST_FALHA;
        end else if (rega != mode_reg) begin
          state_next    = ST_FECHA;
          abortado_next = 1'b1;
        end else if (tmr_zero) begin
          state_next = ST_FECHA;
        end
      end
      ST_FECHA: begin
        if (fault) begin
          state_next = ST_FALHA;
        end else if (tmr_zero) begin
          state_next = ST_IDLE;
          fim_next   = !abortado_reg;
        end
      end
      ST_FALHA: begin
        if (!fault && rega == REGA_NONE) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Timer is (re)loaded on every entry into a timed phase.
  always_comb begin
    tmr_load     = (state_next != state_reg);
    tmr_load_val = '0;
    case (state_next)
      ST_ABRE:  tmr_load_val = LD_ABRE;
      ST_REGA:  tmr_load_val = (mode_reg == REGA_ASP) ? LD_ASP : LD_GOT;
      ST_FECHA: tmr_load_val = LD_FECHA;
      default:  tmr_load_val = '0;
    endcase
  end

  // Output decode from the next state so registered outputs line up with
  // the state they describe. Only the latched mode's valve can open.
  always_comb begin
    asp_next   = 1'b0;
    got_next   = 1'b0;
    bomba_next = 1'b0;
    falha_next = 1'b0;
    case (state_next)
      ST_ABRE, ST_FECHA: begin
        asp_next = (mode_next == REGA_ASP);
        got_next = (mode_next == REGA_GOT);
      end
      ST_REGA: begin
        asp_next   = (mode_next == REGA_ASP);
        got_next   = (mode_next == REGA_GOT);
        bomba_next = (mode_next == REGA_ASP) || (mode_next == REGA_GOT);
      end
      ST_FALHA: begin
        falha_next = 1'b1;
      end
      default: begin
        asp_next = 1'b0;
      end
    endcase
  end

  assign valvula_asp = asp_reg;
  assign valvula_got = got_reg;
  assign bomba       = bomba_reg;
  assign fim_rega    = fim_reg;
  assign falha       = falha_reg;
  assign estado      = state_reg;

`ifdef REGA_STATS_EN
  logic [7:0] ciclos_ok_reg;

  // Advances on the same edge that raises fim_rega; saturates at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ciclos_ok_reg <= 8'd0;
    end else if (fim_next && ciclos_ok_reg != 8'hFF) begin
      ciclos_ok_reg <= ciclos_ok_reg + 8'd1;
    end
  end

  assign ciclos_ok = ciclos_ok_reg;
`endif

endmodule

// File: tb/tb_controle_rega.sv
module tb_controle_rega;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rega;
  logic       erro;
  logic       nivel_baixo;
  logic       valvula_asp, valvula_got, bomba, fim_rega, falha;
  logic [2:0] estado;
`ifdef REGA_STATS_EN
  logic [7:0] ciclos_ok;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [2:0] estado;
    logic       asp, got, bomba, fim, falha;
  } exp_t;

  typedef struct {
    logic [1:0] rega;
    logic       erro, nivel;
    int         edges;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  controle_rega dut (
    .clk         (clk),
    .reset       (reset),
    .rega        (rega),
    .erro        (erro),
    .nivel_baixo (nivel_baixo),
    .valvula_asp (valvula_asp),
    .valvula_got (valvula_got),
    .bomba       (bomba),
    .fim_rega    (fim_rega),
    .falha       (falha),
    .estado      (estado)
`ifdef REGA_STATS_EN
    ,
    .ciclos_ok   (ciclos_ok)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Mutual exclusion of valves and pump/valve consistency, every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((valvula_asp && valvula_got) || (bomba && !(valvula_asp ^ valvula_got))) begin
        failures++;
        $display("FAIL invariant t=%0t: asp=%b got=%b bomba=%b, required one valve max and bomba only with one valve",
                 $time, valvula_asp, valvula_got, bomba);
      end
    end
  end

  function automatic exp_t mke(string n, int st, logic a, logic g, logic b, logic f, logic fl);
    exp_t e;
    e.name = n; e.estado = 3'(st); e.asp = a; e.got = g; e.bomba = b; e.fim = f; e.falha = fl;
    return e;
  endfunction

  function automatic vec_t mk(string n, logic [1:0] r, logic er, logic nb, int ed,
                              int st, logic a, logic g, logic b, logic f, logic fl);
    vec_t v;
    v.rega = r; v.erro = er; v.nivel = nb; v.edges = ed;
    v.e = mke(n, st, a, g, b, f, fl);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_pop();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: queue empty, required an expected entry");
      return;
    end
    e = exp_q.pop_front();
    if (estado !== e.estado || valvula_asp !== e.asp || valvula_got !== e.got ||
        bomba !== e.bomba || fim_rega !== e.fim || falha !== e.falha) begin
      failures++;
      $display("FAIL %s: got estado=%0d asp=%b got=%b bomba=%b fim=%b falha=%b, required estado=%0d asp=%b got=%b bomba=%b fim=%b falha=%b",
               e.name, estado, valvula_asp, valvula_got, bomba, fim_rega, falha,
               e.estado, e.asp, e.got, e.bomba, e.fim, e.falha);
    end else begin
      $display("ok   %s: estado=%0d asp=%b got=%b bomba=%b fim=%b falha=%b",
               e.name, estado, valvula_asp, valvula_got, bomba, fim_rega, falha);
    end
  endtask

`ifdef REGA_STATS_EN
  task automatic check_stats(input string n, input logic [7:0] req);
    checks++;
    if (ciclos_ok !== req) begin
      failures++;
      $display("FAIL %s: got ciclos_ok=%0d, required %0d", n, ciclos_ok, req);
    end else begin
      $display("ok   %s: ciclos_ok=%0d", n, ciclos_ok);
    end
  endtask

  task automatic run_normal();
    rega = 2'b00; tick(1);
    rega = 2'b10; tick(29);
  endtask
`endif

  initial begin
    reset = 1'b1; rega = 2'b00; erro = 1'b0; nivel_baixo = 1'b0;

    //           name            rega  er nb edges  st asp got bomba fim falha
    // normal aspersao: edge 0 is the first edge sampling 10
    tbl.push_back(mk("idle00",        2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("asp_abre1",     2'b10, 0, 0, 1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("asp_abre4",     2'b10, 0, 0, 3,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("asp_rega5",     2'b10, 0, 0, 1,  2, 1, 0, 1, 0, 0));
    tbl.push_back(mk("asp_rega24",    2'b10, 0, 0, 19, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk("asp_fecha25",   2'b10, 0, 0, 1,  3, 1, 0, 0, 0, 0));
    tbl.push_back(mk("asp_fecha28",   2'b10, 0, 0, 3,  3, 1, 0, 0, 0, 0));
    tbl.push_back(mk("asp_fim29",     2'b10, 0, 0, 1,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("asp_norestart", 2'b10, 0, 0, 6,  0, 0, 0, 0, 0, 0));
    // gotejamento after re-arm
    tbl.push_back(mk("rearm",         2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("got_abre1",     2'b01, 0, 0, 1,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("got_rega5",     2'b01, 0, 0, 4,  2, 0, 1, 1, 0, 0));
    tbl.push_back(mk("got_rega44",    2'b01, 0, 0, 39, 2, 0, 1, 1, 0, 0));
    tbl.push_back(mk("got_fecha45",   2'b01, 0, 0, 1,  3, 0, 1, 0, 0, 0));
    tbl.push_back(mk("got_fecha48",   2'b01, 0, 0, 3,  3, 0, 1, 0, 0, 0));
    tbl.push_back(mk("got_fim49",     2'b01, 0, 0, 1,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("got_fimoff",    2'b01, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // abort with 00 at cycle 10; rega back to 10 during FECHA is ignored
    tbl.push_back(mk("ab_arm",        2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ab_abre1",      2'b10, 0, 0, 1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("ab_rega10",     2'b10, 0, 0, 9,  2, 1, 0, 1, 0, 0));
    tbl.push_back(mk("ab_fecha11",    2'b00, 0, 0, 1,  3, 1, 0, 0, 0, 0));
    tbl.push_back(mk("ab_fecha14",    2'b10, 0, 0, 3,  3, 1, 0, 0, 0, 0));
    tbl.push_back(mk("ab_idle15",     2'b10, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ab_stay",       2'b10, 0, 0, 3,  0, 0, 0, 0, 0, 0));
    // gotejamento aborted from ABRE by the other mode
    tbl.push_back(mk("ga_arm",        2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ga_abre1",      2'b01, 0, 0, 1,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ga_fecha1",     2'b10, 0, 0, 1,  3, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ga_fecha4",     2'b00, 0, 0, 3,  3, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ga_idle",       2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // nivel_baixo at cycle 8
    tbl.push_back(mk("f_arm",         2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("f_abre1",       2'b10, 0, 0, 1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("f_rega8",       2'b10, 0, 0, 7,  2, 1, 0, 1, 0, 0));
    tbl.push_back(mk("f_falha9",      2'b10, 0, 1, 1,  4, 0, 0, 0, 0, 1));
    tbl.push_back(mk("f_hold_nivel",  2'b00, 0, 1, 3,  4, 0, 0, 0, 0, 1));
    tbl.push_back(mk("f_hold_rega",   2'b10, 0, 0, 2,  4, 0, 0, 0, 0, 1));
    tbl.push_back(mk("f_hold_erro",   2'b00, 1, 0, 1,  4, 0, 0, 0, 0, 1));
    tbl.push_back(mk("f_exit",        2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // start blocked by erro / nivel_baixo, then erro fault in ABRE
    tbl.push_back(mk("e_arm",         2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("e_blk_erro",    2'b10, 1, 0, 3,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("e_blk_nivel",   2'b10, 0, 1, 2,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("e_start",       2'b10, 0, 0, 1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("e_falha",       2'b10, 1, 0, 1,  4, 0, 0, 0, 0, 1));
    tbl.push_back(mk("e_exit",        2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // fault during FECHA suppresses completion
    tbl.push_back(mk("ff_arm",        2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ff_abre1",      2'b01, 0, 0, 1,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ff_fecha",      2'b00, 0, 0, 1,  3, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ff_falha",      2'b00, 0, 1, 1,  4, 0, 0, 0, 0, 1));
    tbl.push_back(mk("ff_exit",       2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // invalid command with armado set
    tbl.push_back(mk("inv_arm",       2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("inv11",         2'b11, 0, 0, 20, 0, 0, 0, 0, 0, 0));

    tick(2);
    exp_q.push_back(mke("reset", 0, 0, 0, 0, 0, 0));
    compare_pop();
    #3 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rega        = tbl[i].rega;
      erro        = tbl[i].erro;
      nivel_baixo = tbl[i].nivel;
      exp_q.push_back(tbl[i].e);
      tick(tbl[i].edges);
      compare_pop();
    end

    // asynchronous reset between edges in the middle of REGA
    rega = 2'b00; tick(1);
    rega = 2'b10;
    exp_q.push_back(mke("pre_rst_rega6", 2, 1, 0, 1, 0, 0));
    tick(6);
    compare_pop();
    #3 reset = 1'b1;
    exp_q.push_back(mke("async_rst", 0, 0, 0, 0, 0, 0));
    #1 compare_pop();
    tick(2);
    #3 reset = 1'b0;
    // armado comes out of reset set: held 10 starts immediately
    exp_q.push_back(mke("rst_armado", 1, 1, 0, 0, 0, 0));
    tick(1);
    compare_pop();

`ifdef REGA_STATS_EN
    #2 reset = 1'b1;
    tick(1);
    check_stats("stats_reset", 8'd0);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) run_normal();
    check_stats("stats_3", 8'd3);
    for (int i = 0; i < 297; i++) run_normal();
    check_stats("stats_sat", 8'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
